// File: rtl/dmem_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_store_buffer
//  Description : Data-memory stage placed after the CPU MEM stage. A
//                word-addressed RAM sits behind a small in-order store FIFO.
//                Stores enter the FIFO at once and drain to the RAM in
//                cycles with no load. Loads forward from the youngest
//                matching pending store, otherwise they read the RAM.
//
//  Ports       : clock, reset        - clock, synchronous active-high reset
//                DMEM_address        - byte address, word index [ADDR_W+1:2]
//                write_data          - store data
//                DMEM_WRITE          - store request this cycle
//                mem_read            - load request this cycle
//                read_data           - combinational load data (0 if no load)
//                sb_count            - pending stores
//                sb_empty / sb_full  - FIFO status
//                drain_valid         - FIFO head is written to RAM this cycle
//                drain_addr          - word index of the drained entry
//
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_store_buffer #(
    parameter int SB_DEPTH = 4,
    parameter int ADDR_W   = 10
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [31:0]                 DMEM_address,
    input  logic [31:0]                 write_data,
    input  logic                        DMEM_WRITE,
    input  logic                        mem_read,
    output logic [31:0]                 read_data,
    output logic [$clog2(SB_DEPTH):0]   sb_count,
    output logic                        sb_empty,
    output logic                        sb_full,
    output logic                        drain_valid,
    output logic [ADDR_W-1:0]           drain_addr
);

    localparam int c_PTR_W     = $clog2(SB_DEPTH);
    localparam int c_CNT_W     = c_PTR_W + 1;
    localparam int c_RAM_WORDS = 1 << ADDR_W;

    // FIFO storage and pointers
    logic [ADDR_W-1:0]  r_idx  [SB_DEPTH];
    logic [31:0]        r_data [SB_DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    // Data RAM (not reset)
    logic [31:0]        r_ram [0:c_RAM_WORDS-1];

    logic [ADDR_W-1:0]  w_idx;
    logic               w_drain;
    logic               w_fwd_hit;
    logic [31:0]        w_fwd_data;
    logic [c_PTR_W-1:0] w_scan_ptr;
    logic               w_unused_addr_bits;

    assign w_idx              = DMEM_address[ADDR_W+1:2];
    assign w_unused_addr_bits = ^{DMEM_address[31:ADDR_W+2], DMEM_address[1:0]};

    // Draining is suppressed while reset is high so that stores pending at
    // reset are discarded instead of slipping into the RAM on the reset edge.
    assign w_drain = (r_count != '0) && !mem_read && !reset;

    // Forwarding search: walk the valid entries oldest to youngest so that
    // the last match seen (the youngest) wins.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_scan_ptr = r_head;
        for (int k = 0; k < SB_DEPTH; k++) begin
            w_scan_ptr = r_head + c_PTR_W'(k);
            if ((c_CNT_W'(k) < r_count) && (r_idx[w_scan_ptr] == w_idx)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_data[w_scan_ptr];
            end
        end
    end

    always_comb begin
        read_data = '0;
        if (mem_read) begin
            read_data = w_fwd_hit ? w_fwd_data : r_ram[w_idx];
        end
    end

    // Pointer and occupancy state
    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (DMEM_WRITE) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_drain) begin
                r_head <= r_head + 1'b1;
            end
            case ({DMEM_WRITE, w_drain})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload. When full, the tail slot equals the head slot; the
    // drain below still sees the old head contents on this edge.
    always_ff @(posedge clock) begin
        if (DMEM_WRITE) begin
            r_idx[r_tail]  <= w_idx;
            r_data[r_tail] <= write_data;
        end
    end

    always_ff @(posedge clock) begin
        if (w_drain) begin
            r_ram[r_idx[r_head]] <= r_data[r_head];
        end
    end

    assign sb_count    = r_count;
    assign sb_empty    = (r_count == '0);
    assign sb_full     = (r_count == c_CNT_W'(SB_DEPTH));
    assign drain_valid = w_drain;
    assign drain_addr  = w_drain ? r_idx[r_head] : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_store_buffer
//  Description : Self-checking bench for dmem_store_buffer. A queue-based
//                model of pending stores plus a model RAM predicts every
//                output on every cycle; directed sequences add literal
//                expectations, followed by a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_store_buffer;

    localparam int SB_DEPTH = 4;
    localparam int ADDR_W   = 10;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [31:0]               addr;
    logic [31:0]               wdata;
    logic                      we;
    logic                      re;
    logic [31:0]               read_data;
    logic [$clog2(SB_DEPTH):0] sb_count;
    logic                      sb_empty;
    logic                      sb_full;
    logic                      drain_valid;
    logic [ADDR_W-1:0]         drain_addr;

    dmem_store_buffer #(.SB_DEPTH(SB_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock        (clk),
        .reset        (rst),
        .DMEM_address (addr),
        .write_data   (wdata),
        .DMEM_WRITE   (we),
        .mem_read     (re),
        .read_data    (read_data),
        .sb_count     (sb_count),
        .sb_empty     (sb_empty),
        .sb_full      (sb_full),
        .drain_valid  (drain_valid),
        .drain_addr   (drain_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [31:0]       data;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_ram   [1 << ADDR_W];
    bit          m_known [1 << ADDR_W];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Youngest pending store wins, otherwise the model RAM (if ever written).
    function automatic bit model_load(input logic [ADDR_W-1:0] idx, output logic [31:0] val);
        for (int k = q.size() - 1; k >= 0; k--) begin
            if (q[k].idx == idx) begin
                val = q[k].data;
                return 1'b1;
            end
        end
        val = m_ram[idx];
        return m_known[idx];
    endfunction

    // Per-cycle compare against the model, then advance the model across
    // the coming rising edge.
    initial begin
        logic [ADDR_W-1:0] idx;
        logic [31:0]       exp_rd;
        bit                known;
        bit                exp_drain;
        ent_t              e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            idx       = addr[ADDR_W+1:2];
            exp_drain = !rst && (q.size() > 0) && !re;
            chk("sb_count", {29'd0, sb_count}, 32'(q.size()));
            chk("sb_empty", {31'd0, sb_empty}, {31'd0, q.size() == 0});
            chk("sb_full", {31'd0, sb_full}, {31'd0, q.size() == SB_DEPTH});
            chk("drain_valid", {31'd0, drain_valid}, {31'd0, exp_drain});
            chk("drain_addr", {22'd0, drain_addr}, exp_drain ? {22'd0, q[0].idx} : 32'd0);
            if (re) begin
                known = model_load(idx, exp_rd);
                if (known) chk("read_data", read_data, exp_rd);
            end else begin
                chk("read_data_idle", read_data, 32'd0);
            end
            if (rst) begin
                q.delete();
            end else begin
                if (exp_drain) begin
                    m_ram[q[0].idx]   = q[0].data;
                    m_known[q[0].idx] = 1'b1;
                    void'(q.pop_front());
                end
                if (we) begin
                    e.idx  = idx;
                    e.data = wdata;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic set_in(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d);
        we    = w;
        re    = r;
        addr  = a;
        wdata = d;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] tmp;
        logic [3:0]  k4;
        int          r;

        rst = 1'b1;
        set_in(0, 0, 32'd0, 32'd0);
        next();
        next();
        rst = 1'b0;

        // Reset state
        #2;
        chk("reset_count", {29'd0, sb_count}, 32'd0);
        chk("reset_empty", {31'd0, sb_empty}, 32'd1);
        chk("reset_full", {31'd0, sb_full}, 32'd0);
        chk("reset_drain_valid", {31'd0, drain_valid}, 32'd0);

        // Single store, drain, load back from RAM
        set_in(1, 0, 32'h10, 32'hA5A5A5A5);
        next();
        set_in(0, 0, 32'd0, 32'd0);
        #2;
        chk("s1_count", {29'd0, sb_count}, 32'd1);
        chk("s1_drain_valid", {31'd0, drain_valid}, 32'd1);
        chk("s1_drain_addr", {22'd0, drain_addr}, 32'd4);
        next();
        chk("s1_empty", {31'd0, sb_empty}, 32'd1);
        set_in(0, 1, 32'h10, 32'd0);
        #2 chk("s1_load", read_data, 32'hA5A5A5A5);
        next();

        // Youngest forward
        set_in(1, 0, 32'h20, 32'h11);
        next();
        set_in(1, 0, 32'h20, 32'h22);
        next();
        set_in(0, 1, 32'h20, 32'd0);
        #2;
        chk("s2_forward", read_data, 32'h22);
        chk("s2_no_drain", {31'd0, drain_valid}, 32'd0);
        next();
        set_in(0, 0, 32'd0, 32'd0);
        next();
        next();
        set_in(0, 1, 32'h20, 32'd0);
        #2 chk("s2_ram", read_data, 32'h22);
        next();

        // Fill via load+store cycles, then store while full
        for (int k = 0; k < 4; k++) begin
            set_in(1, 1, 32'h30 + 32'(4 * k), 32'h31 + 32'(k));
            #2 chk("s3_no_drain", {31'd0, drain_valid}, 32'd0);
            next();
        end
        chk("s3_count_full", {29'd0, sb_count}, 32'd4);
        chk("s3_full", {31'd0, sb_full}, 32'd1);
        set_in(1, 0, 32'h40, 32'h5);
        #2;
        chk("s3_full_drain", {31'd0, drain_valid}, 32'd1);
        chk("s3_full_drain_addr", {22'd0, drain_addr}, 32'd12);
        next();
        chk("s3_count_stays", {29'd0, sb_count}, 32'd4);
        set_in(0, 0, 32'd0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            #2 chk("s3_drain_order", {22'd0, drain_addr}, 32'd13 + 32'(k));
            next();
        end
        for (int k = 0; k < 5; k++) begin
            set_in(0, 1, 32'h30 + 32'(4 * k), 32'd0);
            #2 chk("s3_ram", read_data, (k == 4) ? 32'h5 : 32'h31 + 32'(k));
            next();
        end

        // Reset discards pending stores
        for (int k = 0; k < 3; k++) begin
            set_in(1, 0, 32'h50 + 32'(4 * k), 32'd1 + 32'(k));
            next();
            set_in(0, 0, 32'd0, 32'd0);
            next();
        end
        for (int k = 0; k < 3; k++) begin
            set_in(1, 1, 32'h50 + 32'(4 * k), 32'hBAD0 + 32'(k));
            next();
        end
        chk("s4_count3", {29'd0, sb_count}, 32'd3);
        rst = 1'b1;
        set_in(0, 0, 32'd0, 32'd0);
        #2 chk("s4_reset_no_drain", {31'd0, drain_valid}, 32'd0);
        next();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #2 chk("s4_idle_no_drain", {31'd0, drain_valid}, 32'd0);
            next();
        end
        chk("s4_count0", {29'd0, sb_count}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            set_in(0, 1, 32'h50 + 32'(4 * k), 32'd0);
            #2 chk("s4_ram_unchanged", read_data, 32'd1 + 32'(k));
            next();
        end

        // Pointer wrap
        for (int k = 0; k < 10; k++) begin
            set_in(1, 0, 32'h100 + 32'(4 * k), 32'h1000 + 32'(k));
            next();
            set_in(0, 0, 32'd0, 32'd0);
            #2 chk("s5_drain_addr", {22'd0, drain_addr}, 32'h40 + 32'(k));
            next();
        end
        for (int k = 0; k < 10; k++) begin
            set_in(0, 1, 32'h100 + 32'(4 * k), 32'd0);
            #2 chk("s5_load", read_data, 32'h1000 + 32'(k));
            next();
        end

        // Idle read is zero; RAM load is combinational
        set_in(0, 0, 32'h200, 32'd0);
        #2 chk("s6_idle_zero", read_data, 32'd0);
        set_in(1, 0, 32'h200, 32'hDEADBEEF);
        next();
        set_in(0, 0, 32'd0, 32'd0);
        next();
        set_in(0, 1, 32'h200, 32'd0);
        #2 chk("s6_ram_load", read_data, 32'hDEADBEEF);
        next();

        // Randomized phase over a small address window
        for (int i = 0; i < 3000; i++) begin
            tmp = $urandom();
            k4  = 4'($urandom_range(0, 15));
            r   = $urandom_range(0, 199);
            rst = (r == 0);
            if (r < 80)
                set_in(1, 0, {tmp[31:12], 6'b110000, k4, tmp[1:0]}, $urandom());
            else if (r < 160)
                set_in(0, 1, {tmp[31:12], 6'b110000, k4, tmp[1:0]}, $urandom());
            else if (r < 175 && q.size() < SB_DEPTH)
                set_in(1, 1, {tmp[31:12], 6'b110000, k4, tmp[1:0]}, $urandom());
            else
                set_in(0, 0, {tmp[31:12], 6'b110000, k4, tmp[1:0]}, $urandom());
            next();
        end
        rst = 1'b0;
        set_in(0, 0, 32'd0, 32'd0);
        for (int i = 0; i < SB_DEPTH + 1; i++) next();
        chk("final_empty", {31'd0, sb_empty}, 32'd1);
        for (int k = 0; k < 16; k++) begin
            set_in(0, 1, 32'hC00 + 32'(4 * k), 32'd0);
            next();
        end
        set_in(0, 0, 32'd0, 32'd0);
        next();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Data-memory stage block sitting directly downstream of the pipelined CPU's MEM stage.
- Consumes the CPU's DMEM_address, write_data and DMEM_WRITE, and produces read_data, which the MEM/WB pipe register captures at the same clock edge.
- Contains a word-addressed data RAM fronted by a small in-order store FIFO.
- Stores retire into the FIFO immediately and drain to the RAM in cycles with no load. Loads forward from the youngest matching pending store.

Parameters:
- SB_DEPTH, 4: store FIFO entries; power of two, at least 2.
- ADDR_W, 10: RAM word-index width; the RAM holds 2^ADDR_W 32-bit words.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- DMEM_address  in  32  byte address from the MEM stage; the word index is bits [ADDR_W+1:2]; other bits are ignored.
- write_data  in  32  store data.
- DMEM_WRITE  in  1  store request this cycle.
- mem_read  in  1  load request this cycle (decoded load in MEM).
- read_data  out  32  combinational load data.
- sb_count  out  log2(SB_DEPTH)+1  number of pending stores.
- sb_empty  out  1  sb_count==0.
- sb_full  out  1  sb_count==SB_DEPTH.
- drain_valid  out  1  a FIFO head is written to the RAM this cycle.
- drain_addr  out  ADDR_W  word index being drained (valid when drain_valid is high).

Behaviour:
- Reset:
  - At a rising edge with reset high: head, tail and count clear to 0.
  - sb_empty=1, sb_full=0, drain_valid=0, drain_addr=0.
  - RAM contents are not reset.
  - Stores pending when reset is asserted are discarded and never reach the RAM.
- FIFO storage: circular, with head/tail pointers of log2(SB_DEPTH) bits that wrap naturally. Each entry holds {word index, data}.
- Enqueue: if DMEM_WRITE=1 at an edge, {index, write_data} is written at the tail; tail advances by 1.
- Drain condition: count>0 and mem_read=0. drain_valid and drain_addr are combinational from the pre-edge state.
- Drain action: on the edge, RAM[head.index] <= head.data and head advances by 1. Only entries present at the start of the cycle may drain; a store enqueued this cycle drains at the earliest one cycle later.
- Count update per edge: +1 on enqueue only, -1 on drain only, unchanged when both happen.
- Full plus store: mem_read=0 is implied, so the head drains and the new store enqueues in the same cycle. Count stays at SB_DEPTH and no store is ever lost.
- Loads: when mem_read=1, read_data is the data of the youngest FIFO entry whose index equals the load index, searching from tail-1 back to head. If no entry matches, read_data is RAM[index], read asynchronously. When mem_read=0, read_data=0.
- Repeated stores to one address: each store is a separate entry; they drain in program order, so the RAM ends with the youngest value.
- mem_read and DMEM_WRITE both high: illegal (the CPU never issues both). The store still enqueues; read_data returns the pre-edge lookup; no drain occurs that cycle.
- Starvation: a continuous run of loads blocks draining. Count never exceeds SB_DEPTH, because every store cycle has mem_read=0 and therefore drains when full.
- Ordering: the RAM write-port order exactly equals store issue order.

Test Plan:
- Reset, then store addr 0x10/data 0xA5A5A5A5 and idle -> sb_count 1 after the edge; next cycle drain_valid=1, drain_addr=4; sb_empty=1 after that edge; a subsequent load at 0x10 returns 0xA5A5A5A5 from the RAM.
- Store 0x20<=0x11 and 0x20<=0x22 on back-to-back cycles, then load 0x20 in the following cycle -> read_data=0x22 (youngest forward), no drain during the load; after two idle cycles the RAM holds 0x22 at index 8.
- Four consecutive loads with interleaved stores so the FIFO reaches full (count 4, sb_full=1), then store 0x40<=0x5 -> drain_valid=1 for the oldest entry in the same cycle, count stays 4; all 5 stores reach the RAM in order.
- Fill the FIFO to 3 entries, assert reset for one edge, then idle 5 cycles -> sb_count=0, drain_valid stays 0 throughout; the RAM is unchanged at those indexes.
- Pointer wrap: issue 10 stores to distinct addresses 0x100+4k (k=0..9), each followed by an idle cycle -> drain_addr follows 0x40..0x49 in order; loads afterwards return each stored value.
- mem_read=0 with a nonzero DMEM_address -> read_data=0x00000000; a load to an address with no buffered entry and RAM value 0xDEADBEEF -> read_data=0xDEADBEEF combinationally, in the same cycle.
